// File: rtl/pc_fetch_controller.sv
// PC sequencing and instruction-fetch handshake with stall hold, branch redirect and imem timeout.
// Optional performance counters are built when PC_FETCH_PERF_EN is defined.
module pc_fetch_controller #(
  parameter int ADDR_W  = 32,
  parameter int PC_INC  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              stall_in,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              imem_ack,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              le_pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic              le_if_id,
  output logic              flush_if_id,
  output logic              redirect_pending,
  output logic              fetch_error,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_ERROR} state_t;

  state_t            state, state_nxt;
  logic              pending, pending_nxt;
  logic [ADDR_W-1:0] tgt_q, tgt_nxt;
  logic [7:0]        wait_cnt, wait_nxt;
  logic              err_q;
  logic              consume;
  logic              redir;
  logic [ADDR_W-1:0] redir_tgt, seq_pc;

  // A same-cycle branch pulse takes priority over a previously captured target.
  assign redir     = pending | branch_taken;
  assign redir_tgt = branch_taken ? branch_target : tgt_q;
  assign seq_pc    = pc_cur + ADDR_W'(PC_INC);

  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    consume     = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = '0;
    le_pc       = 1'b0;
    pc_next     = '0;
    le_if_id    = 1'b0;
    flush_if_id = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_cur;
        if (imem_ack) begin
          wait_nxt = '0;
          if (redir) begin
            le_pc       = 1'b1;
            pc_next     = redir_tgt;
            flush_if_id = 1'b1;
            consume     = 1'b1;
          end else if (!stall_in) begin
            le_pc    = 1'b1;
            pc_next  = seq_pc;
            le_if_id = 1'b1;
          end else begin
            state_nxt = S_HOLD;
          end
        end else begin
          wait_nxt = wait_cnt + 8'd1;
          if (wait_cnt == 8'(TIMEOUT - 1)) state_nxt = S_ERROR;
        end
      end
      S_HOLD: begin
        if (redir) begin
          le_pc       = 1'b1;
          pc_next     = redir_tgt;
          flush_if_id = 1'b1;
          consume     = 1'b1;
          state_nxt   = S_FETCH;
        end else if (!stall_in) begin
          le_pc     = 1'b1;
          pc_next   = seq_pc;
          le_if_id  = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: ;
    endcase
    // Reset abandons any in-flight request: nothing leaves the block that cycle.
    if (reset) begin
      imem_req    = 1'b0;
      imem_addr   = '0;
      le_pc       = 1'b0;
      pc_next     = '0;
      le_if_id    = 1'b0;
      flush_if_id = 1'b0;
    end
  end

  always_comb begin
    pending_nxt = pending;
    tgt_nxt     = tgt_q;
    if (consume) begin
      pending_nxt = 1'b0;
    end else if (branch_taken) begin
      pending_nxt = 1'b1;
      tgt_nxt     = branch_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      pending  <= 1'b0;
      tgt_q    <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      tgt_q    <= tgt_nxt;
      wait_cnt <= wait_nxt;
      err_q    <= err_q | (state_nxt == S_ERROR);
    end
  end

  assign redirect_pending = pending & ~reset;
  assign fetch_error      = err_q & ~reset;

`ifdef PC_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (le_pc && !flush_if_id) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (state == S_HOLD)       stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_count = reset ? 32'd0 : fetch_cnt_q;
  assign stall_count = reset ? 32'd0 : stall_cnt_q;
`else
  assign fetch_count = 32'd0;
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Bench for pc_fetch_controller: directed vector table, hand sequences and a randomized model run.
module tb_pc_fetch_controller;
  logic        clk = 1'b0;
  logic        reset, stall_in, branch_taken, imem_ack;
  logic [31:0] pc_cur, branch_target;
  logic        imem_req, le_pc, le_if_id, flush_if_id, redirect_pending, fetch_error;
  logic [31:0] imem_addr, pc_next, fetch_count, stall_count;

  int checks = 0;
  int failures = 0;

  pc_fetch_controller #(.ADDR_W(32), .PC_INC(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur), .stall_in(stall_in),
    .branch_taken(branch_taken), .branch_target(branch_target), .imem_ack(imem_ack),
    .imem_req(imem_req), .imem_addr(imem_addr), .le_pc(le_pc), .pc_next(pc_next),
    .le_if_id(le_if_id), .flush_if_id(flush_if_id), .redirect_pending(redirect_pending),
    .fetch_error(fetch_error), .fetch_count(fetch_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change after the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic r, input logic a, input logic s, input logic b,
                       input logic [31:0] t, input logic [31:0] pc);
    @(negedge clk);
    reset = r; imem_ack = a; stall_in = s; branch_taken = b;
    branch_target = t; pc_cur = pc;
    #1;
  endtask

  typedef struct {
    logic rst, ack, stall, br;
    logic [31:0] tgt, pc;
    logic req, le, ifid, fl, pend, err;
    logic [31:0] nxt;
    logic chk_perf;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic ack, input logic stall,
                              input logic br, input logic [31:0] tgt, input logic [31:0] pc,
                              input logic req, input logic le, input logic ifid, input logic fl,
                              input logic pend, input logic [31:0] nxt, input logic cp);
    vec_t v;
    v.rst = rst; v.ack = ack; v.stall = stall; v.br = br; v.tgt = tgt; v.pc = pc;
    v.req = req; v.le = le; v.ifid = ifid; v.fl = fl; v.pend = pend; v.err = 1'b0;
    v.nxt = nxt; v.chk_perf = cp;
    return v;
  endfunction

  vec_t tbl[17];

  // Reference model state for the random run
  int          m_phase;   // 0 idle, 1 fetching, 2 holding, 3 error
  bit          m_pend, m_err;
  logic [31:0] m_tgt, m_pc;
  int          m_wait;
  logic [31:0] m_fcnt, m_scnt;

  initial begin
    logic [31:0] pc;
    reset = 1'b1; stall_in = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
    pc_cur = '0; branch_target = '0;

    //          rst ack stl br tgt        pc            req le ifid fl pend nxt   perf
    tbl[0]  = mk(1, 0, 0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 0, 32'h0,   0);
    tbl[1]  = mk(0, 0, 0, 0, 32'h0,   32'h40,       0, 0, 0, 0, 0, 32'h0,   0);
    tbl[2]  = mk(0, 0, 0, 0, 32'h0,   32'h40,       1, 0, 0, 0, 0, 32'h0,   0);
    tbl[3]  = mk(0, 0, 0, 0, 32'h0,   32'h40,       1, 0, 0, 0, 0, 32'h0,   0);
    tbl[4]  = mk(0, 0, 0, 0, 32'h0,   32'h40,       1, 0, 0, 0, 0, 32'h0,   0);
    tbl[5]  = mk(0, 1, 1, 0, 32'h0,   32'h40,       1, 0, 0, 0, 0, 32'h0,   0);
    tbl[6]  = mk(0, 0, 1, 0, 32'h0,   32'h40,       0, 0, 0, 0, 0, 32'h0,   0);
    tbl[7]  = mk(0, 0, 0, 0, 32'h0,   32'h40,       0, 1, 1, 0, 0, 32'h44,  0);
    tbl[8]  = mk(0, 0, 0, 1, 32'h200, 32'h100,      1, 0, 0, 0, 0, 32'h0,   1);
    tbl[9]  = mk(0, 0, 0, 0, 32'h0,   32'h100,      1, 0, 0, 0, 1, 32'h0,   0);
    tbl[10] = mk(0, 1, 0, 0, 32'h0,   32'h100,      1, 1, 0, 1, 1, 32'h200, 0);
    tbl[11] = mk(0, 1, 1, 1, 32'h300, 32'h200,      1, 1, 0, 1, 0, 32'h300, 0);
    tbl[12] = mk(0, 1, 0, 0, 32'h0,   32'h300,      1, 1, 1, 0, 0, 32'h304, 0);
    tbl[13] = mk(0, 1, 0, 0, 32'h0,   32'hFFFFFFFC, 1, 1, 1, 0, 0, 32'h0,   0);
    tbl[14] = mk(0, 1, 1, 0, 32'h0,   32'h0,        1, 0, 0, 0, 0, 32'h0,   0);
    tbl[15] = mk(0, 0, 1, 1, 32'h500, 32'h0,        0, 1, 0, 1, 0, 32'h500, 0);
    tbl[16] = mk(0, 0, 0, 0, 32'h0,   32'h500,      1, 0, 0, 0, 0, 32'h0,   0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ack, tbl[i].stall, tbl[i].br, tbl[i].tgt, tbl[i].pc);
      chk($sformatf("vec%0d imem_req", i), imem_req, tbl[i].req);
      chk($sformatf("vec%0d le_pc", i), le_pc, tbl[i].le);
      chk($sformatf("vec%0d le_if_id", i), le_if_id, tbl[i].ifid);
      chk($sformatf("vec%0d flush_if_id", i), flush_if_id, tbl[i].fl);
      chk($sformatf("vec%0d redirect_pending", i), redirect_pending, tbl[i].pend);
      chk($sformatf("vec%0d fetch_error", i), fetch_error, tbl[i].err);
      if (tbl[i].req) chk($sformatf("vec%0d imem_addr", i), imem_addr, tbl[i].pc);
      if (tbl[i].le)  chk($sformatf("vec%0d pc_next", i), pc_next, tbl[i].nxt);
      if (tbl[i].chk_perf) begin
`ifdef PC_FETCH_PERF_EN
        chk("perf fetch_count", fetch_count, 32'd1);
        chk("perf stall_count", stall_count, 32'd2);
`else
        chk("perf fetch_count", fetch_count, 32'd0);
        chk("perf stall_count", stall_count, 32'd0);
`endif
      end
    end

    // Back-to-back sequential fetch with ack always high
    drive(1, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    chk("seq idle le_pc", le_pc, 1'b0);
    pc = 32'h0;
    for (int k = 1; k <= 3; k++) begin
      drive(0, 1, 0, 0, 0, pc);
      chk($sformatf("seq%0d le_pc", k), le_pc, 1'b1);
      chk($sformatf("seq%0d pc_next", k), pc_next, 32'(4 * k));
      chk($sformatf("seq%0d le_if_id", k), le_if_id, 1'b1);
      pc = 32'(4 * k);
    end

    // Timeout into sticky error, then recovery through reset
    drive(1, 0, 0, 0, 0, 32'h80);
    drive(0, 0, 0, 0, 0, 32'h80);
    for (int k = 1; k <= 15; k++) begin
      drive(0, 0, 0, 0, 0, 32'h80);
      chk($sformatf("wait%0d imem_req", k), imem_req, 1'b1);
      chk($sformatf("wait%0d fetch_error", k), fetch_error, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 0, 32'h80);
      chk($sformatf("err%0d fetch_error", k), fetch_error, 1'b1);
      chk($sformatf("err%0d imem_req", k), imem_req, 1'b0);
      chk($sformatf("err%0d le_pc", k), le_pc, 1'b0);
    end
    drive(1, 1, 0, 0, 0, 32'h80);
    chk("err reset fetch_error", fetch_error, 1'b0);
    chk("err reset imem_req", imem_req, 1'b0);
    drive(0, 1, 0, 0, 0, 32'h80);
    chk("err post-reset fetch_error", fetch_error, 1'b0);
    chk("err post-reset le_pc", le_pc, 1'b0);

    // Randomized run against a rule-level model; each segment starts with reset
    for (int seg = 0; seg < 20; seg++) begin
      int thr;
      thr = $urandom_range(0, 4);
      for (int cyc = 0; cyc < 120; cyc++) begin
        logic r, a, s, b;
        logic [31:0] t;
        logic e_req, e_le, e_ifid, e_fl;
        logic [31:0] e_nxt;
        bit redirect, used, was_hold;
        logic [31:0] rt;
        r = (cyc == 0);
        a = ($urandom_range(0, 3) < thr);
        s = ($urandom_range(0, 2) == 0);
        b = ($urandom_range(0, 5) == 0);
        t = $urandom & 32'hFFFFFFFC;
        if (r) m_pc = (seg % 3 == 0) ? 32'hFFFFFFF0 : ($urandom & 32'hFFFFFFFC);
        drive(r, a, s, b, t, m_pc);

        e_req = 0; e_le = 0; e_ifid = 0; e_fl = 0; e_nxt = 0; used = 0;
        redirect = m_pend || b;
        rt = b ? t : m_tgt;
        was_hold = (m_phase == 2);
        if (!r) begin
          chk("rnd redirect_pending", redirect_pending, m_pend);
          chk("rnd fetch_error", fetch_error, m_err);
`ifdef PC_FETCH_PERF_EN
          chk("rnd fetch_count", fetch_count, m_fcnt);
          chk("rnd stall_count", stall_count, m_scnt);
`else
          chk("rnd fetch_count", fetch_count, 32'd0);
          chk("rnd stall_count", stall_count, 32'd0);
`endif
          if (m_phase == 0) m_phase = 1;
          else if (m_phase == 1) begin
            e_req = 1;
            if (a) begin
              m_wait = 0;
              if (redirect) begin e_le = 1; e_nxt = rt; e_fl = 1; used = 1; end
              else if (!s) begin e_le = 1; e_nxt = m_pc + 32'd4; e_ifid = 1; end
              else m_phase = 2;
            end else begin
              m_wait++;
              if (m_wait == 15) begin m_phase = 3; m_err = 1; end
            end
          end else if (m_phase == 2) begin
            if (redirect) begin e_le = 1; e_nxt = rt; e_fl = 1; used = 1; m_phase = 1; end
            else if (!s) begin e_le = 1; e_nxt = m_pc + 32'd4; e_ifid = 1; m_phase = 1; end
          end
          if (used) m_pend = 0;
          else if (b) begin m_pend = 1; m_tgt = t; end
          if (e_le && !e_fl) m_fcnt++;
          if (was_hold) m_scnt++;
        end else begin
          chk("rnd reset redirect_pending", redirect_pending, 1'b0);
          chk("rnd reset fetch_error", fetch_error, 1'b0);
          m_phase = 0; m_pend = 0; m_tgt = 0; m_wait = 0; m_err = 0;
          m_fcnt = 0; m_scnt = 0;
        end

        chk("rnd imem_req", imem_req, e_req);
        chk("rnd le_pc", le_pc, e_le);
        chk("rnd le_if_id", le_if_id, e_ifid);
        chk("rnd flush_if_id", flush_if_id, e_fl);
        if (e_req) chk("rnd imem_addr", imem_addr, m_pc);
        if (e_le) begin
          chk("rnd pc_next", pc_next, e_nxt);
          m_pc = e_nxt;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_fetch_controller.md
Name: pc_fetch_controller

Overview:
- Sequences the program-counter register and the instruction-memory fetch handshake in the pipelined CPU.
- Drives the PC load enable and next-PC value, and handles variable-latency instruction memory.
- Holds fetch on hazard stalls, and applies taken-branch redirects with IF/ID flush.
- Sits between the PC register, instruction memory, IF/ID pipeline register and hazard/branch logic.

Parameters:
ADDR_W, 32, width of PC and addresses
PC_INC, 4, sequential PC increment in bytes
TIMEOUT, 15, max cycles waiting for imem_ack before error (1..255)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
pc_cur  in  ADDR_W  current PC register output
stall_in  in  1  hazard unit stall request
branch_taken  in  1  one-cycle pulse, branch resolved taken
branch_target  in  ADDR_W  target address, valid with branch_taken
imem_ack  in  1  instruction memory data valid for current request
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_W  fetch address
le_pc  out  1  PC register load enable
pc_next  out  ADDR_W  value to load into PC register
le_if_id  out  1  IF/ID register load enable
flush_if_id  out  1  clear IF/ID to bubble
redirect_pending  out  1  branch target captured, not yet applied
fetch_error  out  1  sticky imem timeout flag
fetch_count  out  32  retired fetches (optional feature)
stall_count  out  32  cycles spent in HOLD (optional feature)

Behaviour:
- Reset is synchronous and active-high on clk: state=IDLE, pending=0, target reg=0, wait counter=0, fetch_error=0, counters=0. All outputs are 0 during reset and in IDLE. Reset mid-fetch abandons the request; no le_pc is issued.
- Output timing: imem_req, imem_addr, le_pc, pc_next, le_if_id and flush_if_id are combinational from state, registers and current inputs. fetch_error and the counters are registered.
- Default next PC: pc_next = pc_cur + PC_INC, modulo 2^ADDR_W (0xFFFFFFFC + 4 = 0).
- "Effective redirect" = pending OR branch_taken this cycle. Its target is branch_target if branch_taken is high this cycle, otherwise the target register.
- IDLE: lasts one cycle after reset deasserts, then goes to FETCH.
- FETCH: imem_req=1, imem_addr=pc_cur. The wait counter increments each cycle without ack.
  - On imem_ack with effective redirect: le_pc=1, pc_next=target, flush_if_id=1, le_if_id=0; pending clears; stay in FETCH. stall_in is ignored, because the fetched instruction is discarded.
  - On imem_ack without redirect and stall_in=0: le_pc=1, le_if_id=1; stay in FETCH.
  - On imem_ack without redirect and stall_in=1: le_pc=0, le_if_id=0; go to HOLD.
  - No ack and wait counter reaches TIMEOUT: fetch_error<=1; go to ERROR.
  - The wait counter clears on every ack.
- HOLD: imem_req=0; the fetched instruction is held externally.
  - Effective redirect: apply the redirect exactly as in FETCH; go to FETCH.
  - Else stall_in=0: le_pc=1, le_if_id=1; go to FETCH.
  - Else: remain in HOLD.
- ERROR: all enables and imem_req=0; fetch_error=1. Exits only via reset.
- branch_taken not consumed in the same cycle: pending<=1 and the target register captures branch_target. A later pulse while pending overwrites the target (last wins).
- redirect_pending = pending register value.
- Sequential fetch latency: one cycle minimum, i.e. ack in the same cycle as req gives le_pc in that cycle.

Optional Feature:
- Macro: PC_FETCH_PERF_EN.
- Defined:
  - fetch_count increments on each cycle with le_pc=1 and flush_if_id=0.
  - stall_count increments on each cycle in HOLD.
  - Both wrap at 2^32 and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.
- Ports exist in both builds.

Test Plan:
- Reset, then imem_ack tied to 1 with pc_cur tracking pc_next from 0. Required: first le_pc in cycle 2 after reset release, then pc_next = 4, 8, 12 on consecutive cycles with le_if_id=1 each cycle.
- pc_cur=0x40, ack 3 cycles after req, stall_in=1 for 2 cycles starting at ack. Required: le_pc=0 during both stall cycles, then le_pc=1 with pc_next=0x44 and le_if_id=1. With PC_FETCH_PERF_EN defined, stall_count=2.
- pc_cur=0x100 awaiting ack; branch_taken pulse with target 0x200, ack arrives 2 cycles later. Required: redirect_pending=1 until ack; on ack le_pc=1, pc_next=0x200, flush_if_id=1, le_if_id=0.
- branch_taken (target 0x300) in the same cycle as ack with stall_in=1. Required: immediate redirect, pc_next=0x300, flush_if_id=1, no HOLD entry.
- No ack for TIMEOUT=15 cycles. Required: fetch_error=1 on the next cycle and imem_req=0; both persist until reset, after which everything is 0 again.
- pc_cur=0xFFFFFFFC with ack. Required: pc_next=0x00000000.
